gpu_draw_engine: RTL
====================

GPU_DRAW_ENGINE -- requirements
Module: gpu_draw_engine

Interface
REQ-001 SHALL have parameter RES_W, default 200, framebuffer width in pixels.
REQ-002 SHALL have parameter RES_H, default 150, framebuffer height in pixels.
REQ-003 SHALL have port PIXEL_CLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CPU_WE  input  1  one-cycle register write strobe from the CPU bus bridge.
REQ-006 SHALL have port CPU_ADDR  input  3  register select.
REQ-007 SHALL have port CPU_DATA  input  8  write data.
REQ-008 SHALL have port X_POS  output  8  pixel column to framebuffer, registered.
REQ-009 SHALL have port Y_POS  output  8  pixel row to framebuffer, registered.
REQ-010 SHALL have port COLOR  output  3  pixel colour to framebuffer, registered.
REQ-011 SHALL have port WRITE  output  1  framebuffer write strobe, registered, one pixel per high cycle.
REQ-012 SHALL have port BUSY  output  1  high while a command is executing.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse when a command completes.

Function
REQ-014 SHALL decode CPU_ADDR on CPU_WE: 0 X0, 1 Y0, 2 COL (bits 2:0), 3 W, 4 H, 5 CMD; 6-7 ignored.
REQ-015 SHALL accept writes to addresses 0-4 at any time; an executing command SHALL use values latched at its start.
REQ-016 SHALL decode CMD data: 0x01 PLOT, 0x02 FILL, 0x03 CLEAR; other codes ignored, no BUSY.
REQ-017 SHALL ignore a CMD write while BUSY is high (no queueing, no effect on the running command).
REQ-018 SHALL implement states IDLE, RUN, FINISH; IDLE->RUN on an accepted command, RUN->FINISH after the last pixel, FINISH->IDLE after one cycle.
REQ-019 SHALL, for a command accepted at edge N with P pixels, assert WRITE for exactly P consecutive cycles starting at edge N+1.
REQ-020 SHALL hold BUSY high from edge N through edge N+P+1 (P+1 cycles), and pulse DONE for the single cycle following edge N+P+1.
REQ-021 SHALL, for PLOT, emit one pixel (X0,Y0,COL), or P=0 if X0>=RES_W or Y0>=RES_H.
REQ-022 SHALL, for FILL, emit pixels in raster order (x fastest) over x in X0..min(X0+W,RES_W)-1, y in Y0..min(Y0+H,RES_H)-1.
REQ-023 SHALL compute rectangle ends in 9-bit arithmetic so X0+W and Y0+H never wrap.
REQ-024 SHALL treat W=0, H=0, X0>=RES_W or Y0>=RES_H on FILL as P=0 (BUSY one cycle, DONE pulse, no WRITE).
REQ-025 SHALL, for CLEAR, behave as FILL with X0=0, Y0=0, W=RES_W, H=RES_H, colour COL.
REQ-026 SHALL never drive WRITE high with X_POS>=RES_W or Y_POS>=RES_H.
REQ-027 SHALL hold X_POS, Y_POS, COLOR at their last values when WRITE is low.

Reset
REQ-028 SHALL, on RESET high, immediately force WRITE, BUSY, DONE, X_POS, Y_POS, COLOR and registers X0,Y0,COL,W,H to 0 and state to IDLE.
REQ-029 SHALL abort any command on RESET with no further WRITE and no DONE pulse.
REQ-030 SHALL accept a new command on the first clock edge after RESET deasserts.

Verification
REQ-031 SHALL pass: X0=10,Y0=20,COL=5, CMD=0x01 at edge N -> WRITE high only at cycle N+1 with (10,20,5); BUSY 2 cycles; DONE at N+2.
REQ-032 SHALL pass: X0=198,Y0=148,W=4,H=4,COL=2, FILL -> exactly 4 writes (198,148),(199,148),(198,149),(199,149); BUSY 5 cycles.
REQ-033 SHALL pass: COL=1, CLEAR -> 30000 consecutive writes ending at (199,149); DONE once; no WRITE with x>=200 or y>=150.
REQ-034 SHALL pass: FILL W=3,H=2 running, second CMD=0x02 and X0=50 written mid-run -> original 6 pixels unchanged, no second command.
REQ-035 SHALL pass: W=0 FILL -> no WRITE, BUSY 1 cycle, DONE pulse; PLOT at X0=200 -> no WRITE.
REQ-036 SHALL pass: RESET asserted mid-CLEAR -> WRITE/BUSY low without a clock edge, no DONE, all outputs 0.

Source files
------------

// File: rtl/gpu_draw_engine.sv
// Rectangle/pixel draw engine: CPU-programmed registers drive a raster walker
// that streams PLOT, FILL and CLEAR pixels to a framebuffer port.
module gpu_draw_engine #(
  parameter int RES_W = 200,
  parameter int RES_H = 150
) (
  input  logic       PIXEL_CLOCK,
  input  logic       RESET,
  input  logic       CPU_WE,
  input  logic [2:0] CPU_ADDR,
  input  logic [7:0] CPU_DATA,
  output logic [7:0] X_POS,
  output logic [7:0] Y_POS,
  output logic [2:0] COLOR,
  output logic       WRITE,
  output logic       BUSY,
  output logic       DONE
);

  // state  | meaning
  // IDLE   | waiting for a PLOT/FILL/CLEAR command
  // RUN    | walking the latched rectangle, one pixel per cycle
  // FINISH | single DONE cycle before returning to IDLE
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [8:0] RW = 9'(RES_W);
  localparam logic [8:0] RH = 9'(RES_H);

  state_t     state, state_nx;
  logic [7:0] x0_r, y0_r, w_r, h_r;
  logic [2:0] col_r, col_l;
  logic [8:0] cx, cy, xs, xe, ye;
  logic       more;
  logic       cmd_go;
  logic [8:0] s_x, s_y, e_x, e_y, sum_x, sum_y;
  logic       empty;

  assign cmd_go = CPU_WE && (CPU_ADDR == 3'd5) && (state == IDLE) &&
                  (CPU_DATA >= 8'h01) && (CPU_DATA <= 8'h03);
  assign BUSY   = (state == RUN);
  assign DONE   = (state == FINISH);

  // Rectangle bounds from the register file; 9-bit sums keep X0+W from wrapping.
  always_comb begin
    s_x   = 9'd0;
    s_y   = 9'd0;
    e_x   = RW;
    e_y   = RH;
    empty = 1'b0;
    sum_x = {1'b0, x0_r} + {1'b0, w_r};
    sum_y = {1'b0, y0_r} + {1'b0, h_r};
    case (CPU_DATA)
      8'h01: begin
        s_x   = {1'b0, x0_r};
        s_y   = {1'b0, y0_r};
        e_x   = s_x + 9'd1;
        e_y   = s_y + 9'd1;
        empty = (s_x >= RW) || (s_y >= RH);
      end
      8'h02: begin
        s_x   = {1'b0, x0_r};
        s_y   = {1'b0, y0_r};
        e_x   = (sum_x > RW) ? RW : sum_x;
        e_y   = (sum_y > RH) ? RH : sum_y;
        empty = (w_r == 8'd0) || (h_r == 8'd0) || (s_x >= RW) || (s_y >= RH);
      end
      default: ;
    endcase
  end

  always_ff @(posedge PIXEL_CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_go) state_nx = RUN;
      RUN:     if (!more) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PIXEL_CLOCK or posedge RESET) begin
    if (RESET) begin
      x0_r  <= '0;
      y0_r  <= '0;
      w_r   <= '0;
      h_r   <= '0;
      col_r <= '0;
      col_l <= '0;
      cx    <= '0;
      cy    <= '0;
      xs    <= '0;
      xe    <= '0;
      ye    <= '0;
      more  <= 1'b0;
      WRITE <= 1'b0;
      X_POS <= '0;
      Y_POS <= '0;
      COLOR <= '0;
    end else begin
      WRITE <= 1'b0;
      if (CPU_WE) begin
        case (CPU_ADDR)
          3'd0: x0_r  <= CPU_DATA;
          3'd1: y0_r  <= CPU_DATA;
          3'd2: col_r <= CPU_DATA[2:0];
          3'd3: w_r   <= CPU_DATA;
          3'd4: h_r   <= CPU_DATA;
          default: ;
        endcase
      end
      if (cmd_go) begin
        cx    <= s_x;
        cy    <= s_y;
        xs    <= s_x;
        xe    <= e_x;
        ye    <= e_y;
        col_l <= col_r;
        more  <= !empty;
      end else if ((state == RUN) && more) begin
        WRITE <= 1'b1;
        X_POS <= cx[7:0];
        Y_POS <= cy[7:0];
        COLOR <= col_l;
        if (cx + 9'd1 == xe) begin
          cx <= xs;
          if (cy + 9'd1 == ye) more <= 1'b0;
          else                 cy   <= cy + 9'd1;
        end else begin
          cx <= cx + 9'd1;
        end
      end
    end
  end

endmodule
